// File: rtl/sc_game_statemachine_pkg.sv
// rtl/sc_game_statemachine_pkg.sv - state and select codes for the RoadFighter game-flow FSM
package sc_game_statemachine_pkg;

  localparam int STATE_WIDTH = 3;

  typedef enum logic [STATE_WIDTH-1:0] {
    S_IDLE      = 3'd0,
    S_COUNTDOWN = 3'd1,
    S_PLAY      = 3'd2,
    S_CRASH     = 3'd3,
    S_GAMEOVER  = 3'd4
  } state_t;

  localparam int SEL_CLEAR  = 0;
  localparam int SEL_FILL   = 1;
  localparam int SEL_RANDOM = 2;
  localparam int SEL_HOLD   = 3;

endpackage

// File: rtl/sc_game_statemachine_if.sv
// rtl/sc_game_statemachine_if.sv - game-control inputs and display/status outputs of the FSM
interface sc_game_statemachine_if #(
  parameter int MUX41_SELECTWIDTH = 2,
  parameter int N_CHANNELS        = 8,
  parameter int LIVES             = 3,
  parameter int LEVEL_WIDTH       = 3
);
  localparam int LIVES_WIDTH = $clog2(LIVES + 1);

  logic                                  SC_STATEMACHINE_CLEAR_InHigh;
  logic                                  SC_STATEMACHINE_START_InLow;
  logic                                  SC_STATEMACHINE_TICK_InHigh;
  logic                                  SC_STATEMACHINE_COLLISION_InHigh;
  logic [N_CHANNELS*MUX41_SELECTWIDTH-1:0] SC_STATEMACHINE_SELECT_OutBUS;
  logic [2:0]                            SC_STATEMACHINE_STATE_OutBUS;
  logic                                  SC_STATEMACHINE_LOAD_OutHigh;
  logic [LIVES_WIDTH-1:0]                SC_STATEMACHINE_LIVES_OutBUS;
  logic [LEVEL_WIDTH-1:0]                SC_STATEMACHINE_LEVEL_OutBUS;

  modport master (
    output SC_STATEMACHINE_CLEAR_InHigh, SC_STATEMACHINE_START_InLow,
           SC_STATEMACHINE_TICK_InHigh, SC_STATEMACHINE_COLLISION_InHigh,
    input  SC_STATEMACHINE_SELECT_OutBUS, SC_STATEMACHINE_STATE_OutBUS,
           SC_STATEMACHINE_LOAD_OutHigh, SC_STATEMACHINE_LIVES_OutBUS,
           SC_STATEMACHINE_LEVEL_OutBUS
  );

  modport slave (
    input  SC_STATEMACHINE_CLEAR_InHigh, SC_STATEMACHINE_START_InLow,
           SC_STATEMACHINE_TICK_InHigh, SC_STATEMACHINE_COLLISION_InHigh,
    output SC_STATEMACHINE_SELECT_OutBUS, SC_STATEMACHINE_STATE_OutBUS,
           SC_STATEMACHINE_LOAD_OutHigh, SC_STATEMACHINE_LIVES_OutBUS,
           SC_STATEMACHINE_LEVEL_OutBUS
  );
endinterface

// File: rtl/sc_game_statemachine_tick_downcounter.sv
// rtl/sc_game_statemachine_tick_downcounter.sv - loadable tick down-counter shared by COUNTDOWN and CRASH
module sc_game_statemachine_tick_downcounter #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             tick,
  output logic [WIDTH-1:0] count,
  output logic             last
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (tick) begin
      count <= count - WIDTH'(1);
    end
  end

  assign last = tick & (count == WIDTH'(1));

endmodule

// File: rtl/sc_game_statemachine.sv
// rtl/sc_game_statemachine.sv - registered RoadFighter game-flow FSM driving per-row MUX41 selects
module sc_game_statemachine
  import sc_game_statemachine_pkg::*;
#(
  parameter int MUX41_SELECTWIDTH = 2,
  parameter int N_CHANNELS        = 8,
  parameter int COUNTDOWN_TICKS   = 3,
  parameter int CRASH_TICKS       = 2,
  parameter int TICKS_PER_LEVEL   = 16,
  parameter int LIVES             = 3,
  parameter int LEVEL_WIDTH       = 3
) (
  input  logic                    SC_STATEMACHINE_CLOCK_50,
  input  logic                    SC_STATEMACHINE_RESET_InLow,
  sc_game_statemachine_if.slave   bus
);

  localparam int LIVES_W   = $clog2(LIVES + 1);
  localparam int LVL_CNT_W = $clog2(TICKS_PER_LEVEL + 1);
  localparam int CNT_MAX   = (COUNTDOWN_TICKS > CRASH_TICKS) ? COUNTDOWN_TICKS : CRASH_TICKS;
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam logic [LEVEL_WIDTH-1:0] LEVEL_MAX  = '1;
  localparam logic [LIVES_W-1:0]     LIVES_INIT = LIVES_W'(LIVES);

  logic clk, rst_n, clear, start_n, tick, collision, start_evt;
  assign clk       = SC_STATEMACHINE_CLOCK_50;
  assign rst_n     = SC_STATEMACHINE_RESET_InLow;
  assign clear     = bus.SC_STATEMACHINE_CLEAR_InHigh;
  assign start_n   = bus.SC_STATEMACHINE_START_InLow;
  assign tick      = bus.SC_STATEMACHINE_TICK_InHigh;
  assign collision = bus.SC_STATEMACHINE_COLLISION_InHigh;

  state_t                 state;
  logic                   blink, start_prev, load;
  logic [LVL_CNT_W-1:0]   lvl_cnt;
  logic [LEVEL_WIDTH-1:0] level;
  logic [LIVES_W-1:0]     lives;

  logic             cnt_load, cnt_tick, cnt_last;
  logic [CNT_W-1:0] cnt_load_val, cnt_count;

  assign start_evt = start_prev & ~start_n;

  // Counter is (re)loaded on the same edge the FSM enters a timed state; clear parks it at 0.
  always_comb begin
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    if (clear) begin
      cnt_load = 1'b1;
    end else if (state == S_IDLE && start_evt) begin
      cnt_load     = 1'b1;
      cnt_load_val = CNT_W'(COUNTDOWN_TICKS);
    end else if (state == S_PLAY && collision) begin
      cnt_load     = 1'b1;
      cnt_load_val = CNT_W'(CRASH_TICKS);
    end
  end

  assign cnt_tick = tick & (state == S_COUNTDOWN || state == S_CRASH) & (cnt_count != '0);

  sc_game_statemachine_tick_downcounter #(.WIDTH(CNT_W)) u_tick_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .tick     (cnt_tick),
    .count    (cnt_count),
    .last     (cnt_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      blink      <= 1'b0;
      start_prev <= 1'b1;
      load       <= 1'b0;
      lvl_cnt    <= '0;
      level      <= '0;
      lives      <= LIVES_INIT;
    end else begin
      start_prev <= start_n;
      load       <= 1'b0;
      if (clear) begin
        state   <= S_IDLE;
        blink   <= 1'b0;
        lvl_cnt <= '0;
        level   <= '0;
        lives   <= LIVES_INIT;
      end else begin
        case (state)
          S_IDLE: begin
            if (start_evt) begin
              state   <= S_COUNTDOWN;
              lives   <= LIVES_INIT;
              level   <= '0;
              lvl_cnt <= '0;
            end
          end
          S_COUNTDOWN: begin
            if (cnt_last) begin
              state <= S_PLAY;
              load  <= 1'b1;
            end
          end
          S_PLAY: begin
            if (collision) begin
              state <= S_CRASH;
              if (lives != '0) lives <= lives - LIVES_W'(1);
            end else if (tick) begin
              if (lvl_cnt == LVL_CNT_W'(TICKS_PER_LEVEL - 1)) begin
                lvl_cnt <= '0;
                if (level != LEVEL_MAX) level <= level + LEVEL_WIDTH'(1);
              end else begin
                lvl_cnt <= lvl_cnt + LVL_CNT_W'(1);
              end
            end
          end
          S_CRASH: begin
            if (cnt_last) begin
              if (lives == '0) begin
                state <= S_GAMEOVER;
              end else begin
                state <= S_PLAY;
                load  <= 1'b1;
              end
            end
          end
          S_GAMEOVER: begin
            // A tick outranks start_evt, so a coinciding start press is dropped.
            if (tick) begin
              blink <= ~blink;
            end else if (start_evt) begin
              state <= S_IDLE;
              blink <= 1'b0;
            end
          end
          default: begin
            state <= S_IDLE;
            blink <= 1'b0;
          end
        endcase
      end
    end
  end

  for (genvar r = 0; r < N_CHANNELS; r++) begin : g_row
    localparam logic ODD_ROW = (r % 2) == 1;
    logic [MUX41_SELECTWIDTH-1:0] row_sel;

    always_comb begin
      case (state)
        S_COUNTDOWN: row_sel = MUX41_SELECTWIDTH'(SEL_FILL);
        S_PLAY:      row_sel = MUX41_SELECTWIDTH'(SEL_RANDOM);
        S_CRASH:     row_sel = MUX41_SELECTWIDTH'(SEL_HOLD);
        S_GAMEOVER:  row_sel = (blink ^ ODD_ROW) ? MUX41_SELECTWIDTH'(SEL_HOLD)
                                                 : MUX41_SELECTWIDTH'(SEL_CLEAR);
        default:     row_sel = MUX41_SELECTWIDTH'(SEL_CLEAR);
      endcase
    end

    assign bus.SC_STATEMACHINE_SELECT_OutBUS[r*MUX41_SELECTWIDTH +: MUX41_SELECTWIDTH] = row_sel;
  end

  assign bus.SC_STATEMACHINE_STATE_OutBUS = state;
  assign bus.SC_STATEMACHINE_LOAD_OutHigh = load;
  assign bus.SC_STATEMACHINE_LIVES_OutBUS = lives;
  assign bus.SC_STATEMACHINE_LEVEL_OutBUS = level;

endmodule

// File: tb/tb_sc_game_statemachine.sv
// tb/tb_sc_game_statemachine.sv - directed and randomized bench for sc_game_statemachine
module tb_sc_game_statemachine;

  localparam int SELW = 2;
  localparam int NCH  = 8;
  localparam int CD   = 3;
  localparam int CR   = 2;
  localparam int TPL  = 16;
  localparam int NLIV = 3;
  localparam int LVW  = 3;
  localparam int LVL_MAX = (1 << LVW) - 1;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sc_game_statemachine_if #(
    .MUX41_SELECTWIDTH(SELW), .N_CHANNELS(NCH), .LIVES(NLIV), .LEVEL_WIDTH(LVW)
  ) bus ();

  sc_game_statemachine #(
    .MUX41_SELECTWIDTH(SELW), .N_CHANNELS(NCH), .COUNTDOWN_TICKS(CD),
    .CRASH_TICKS(CR), .TICKS_PER_LEVEL(TPL), .LIVES(NLIV), .LEVEL_WIDTH(LVW)
  ) u_dut (
    .SC_STATEMACHINE_CLOCK_50    (clk),
    .SC_STATEMACHINE_RESET_InLow (rst_n),
    .bus                         (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Game model: phase names, remaining ticks in a timed phase, and play ticks since last level-up.
  int m_phase, m_left, m_play_ticks, m_level, m_lives, m_blink, m_prev, m_load;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    m_phase = 0; m_left = 0; m_play_ticks = 0; m_level = 0;
    m_lives = NLIV; m_blink = 0; m_prev = 1; m_load = 0;
  endtask

  task automatic model_step(input bit clr, input bit sn, input bit tk, input bit co);
    bit pressed;
    pressed = (m_prev == 1) && !sn;
    m_prev  = sn;
    m_load  = 0;
    if (clr) begin
      m_phase = 0; m_left = 0; m_play_ticks = 0; m_level = 0; m_lives = NLIV; m_blink = 0;
    end else begin
      case (m_phase)
        0: if (pressed) begin
          m_phase = 1; m_left = CD; m_lives = NLIV; m_level = 0; m_play_ticks = 0;
        end
        1: if (tk) begin
          m_left--;
          if (m_left == 0) begin m_phase = 2; m_load = 1; end
        end
        2: if (co) begin
          m_phase = 3; m_left = CR; m_lives = (m_lives > 0) ? m_lives - 1 : 0;
        end else if (tk) begin
          m_play_ticks++;
          if (m_play_ticks == TPL) begin
            m_play_ticks = 0;
            if (m_level < LVL_MAX) m_level++;
          end
        end
        3: if (tk) begin
          m_left--;
          if (m_left == 0) begin
            if (m_lives == 0) m_phase = 4;
            else begin m_phase = 2; m_load = 1; end
          end
        end
        default: if (tk) m_blink = 1 - m_blink;
          else if (pressed) begin m_phase = 0; m_blink = 0; end
      endcase
    end
  endtask

  function automatic logic [NCH*SELW-1:0] exp_sel();
    logic [NCH*SELW-1:0] v;
    int code;
    v = '0;
    for (int r = 0; r < NCH; r++) begin
      if (m_phase == 4) code = (((r % 2) == 0) == (m_blink == 1)) ? 3 : 0;
      else              code = m_phase;
      v[r*SELW +: SELW] = SELW'(code);
    end
    return v;
  endfunction

  task automatic check_all(input string tag);
    chk({tag, ".state"}, 32'(bus.SC_STATEMACHINE_STATE_OutBUS), 32'(m_phase));
    chk({tag, ".sel"},   32'(bus.SC_STATEMACHINE_SELECT_OutBUS), 32'(exp_sel()));
    chk({tag, ".load"},  32'(bus.SC_STATEMACHINE_LOAD_OutHigh), 32'(m_load));
    chk({tag, ".lives"}, 32'(bus.SC_STATEMACHINE_LIVES_OutBUS), 32'(m_lives));
    chk({tag, ".level"}, 32'(bus.SC_STATEMACHINE_LEVEL_OutBUS), 32'(m_level));
  endtask

  task automatic cycle(input string tag, input bit clr, input bit sn, input bit tk, input bit co);
    @(negedge clk);
    bus.SC_STATEMACHINE_CLEAR_InHigh     = clr;
    bus.SC_STATEMACHINE_START_InLow      = sn;
    bus.SC_STATEMACHINE_TICK_InHigh      = tk;
    bus.SC_STATEMACHINE_COLLISION_InHigh = co;
    @(posedge clk);
    model_step(clr, sn, tk, co);
    #1;
    check_all(tag);
  endtask

  task automatic press_start(input string tag);
    cycle(tag, 0, 0, 0, 0);
    cycle(tag, 0, 1, 0, 0);
  endtask

  initial begin
    bus.SC_STATEMACHINE_CLEAR_InHigh     = 1'b0;
    bus.SC_STATEMACHINE_START_InLow      = 1'b1;
    bus.SC_STATEMACHINE_TICK_InHigh      = 1'b0;
    bus.SC_STATEMACHINE_COLLISION_InHigh = 1'b0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // T1: idle then start press
    cycle("t1_idle", 0, 1, 0, 0);
    chk("t1_state_idle", 32'(bus.SC_STATEMACHINE_STATE_OutBUS), 0);
    cycle("t1_press", 0, 0, 0, 0);
    chk("t1_state_cd", 32'(bus.SC_STATEMACHINE_STATE_OutBUS), 1);
    chk("t1_sel_fill", 32'(bus.SC_STATEMACHINE_SELECT_OutBUS), 32'h5555);
    cycle("t1_release", 0, 1, 0, 0);

    // T2: countdown into play
    repeat (CD) cycle("t2_tick", 0, 1, 1, 0);
    chk("t2_state_play", 32'(bus.SC_STATEMACHINE_STATE_OutBUS), 2);
    chk("t2_load", 32'(bus.SC_STATEMACHINE_LOAD_OutHigh), 1);
    chk("t2_sel_random", 32'(bus.SC_STATEMACHINE_SELECT_OutBUS), 32'hAAAA);
    cycle("t2_after", 0, 1, 0, 0);
    chk("t2_load_drop", 32'(bus.SC_STATEMACHINE_LOAD_OutHigh), 0);

    // T3: levels and saturation
    repeat (16) cycle("t3_tick", 0, 1, 1, 0);
    chk("t3_level1", 32'(bus.SC_STATEMACHINE_LEVEL_OutBUS), 1);
    repeat (112) cycle("t3_tick", 0, 1, 1, 0);
    chk("t3_level7", 32'(bus.SC_STATEMACHINE_LEVEL_OutBUS), 7);
    repeat (16) cycle("t3_tick", 0, 1, 1, 0);
    chk("t3_level_sat", 32'(bus.SC_STATEMACHINE_LEVEL_OutBUS), 7);

    // T4: crash with coinciding tick, then resume
    cycle("t4_crash", 0, 1, 1, 1);
    chk("t4_state_crash", 32'(bus.SC_STATEMACHINE_STATE_OutBUS), 3);
    chk("t4_lives", 32'(bus.SC_STATEMACHINE_LIVES_OutBUS), 2);
    chk("t4_sel_hold", 32'(bus.SC_STATEMACHINE_SELECT_OutBUS), 32'hFFFF);
    repeat (CR) cycle("t4_tick", 0, 1, 1, 0);
    chk("t4_resume", 32'(bus.SC_STATEMACHINE_STATE_OutBUS), 2);
    chk("t4_load", 32'(bus.SC_STATEMACHINE_LOAD_OutHigh), 1);

    // T5: two more crashes end the game
    repeat (2) begin
      cycle("t5_crash", 0, 1, 0, 1);
      repeat (CR) cycle("t5_tick", 0, 1, 1, 0);
    end
    chk("t5_gameover", 32'(bus.SC_STATEMACHINE_STATE_OutBUS), 4);
    cycle("t5_blink", 0, 1, 1, 0);
    chk("t5_row0_on", 32'(bus.SC_STATEMACHINE_SELECT_OutBUS[1:0]), 3);
    chk("t5_row1_off", 32'(bus.SC_STATEMACHINE_SELECT_OutBUS[3:2]), 0);
    cycle("t5_blink", 0, 1, 1, 0);
    chk("t5_row0_off", 32'(bus.SC_STATEMACHINE_SELECT_OutBUS[1:0]), 0);
    chk("t5_row1_on", 32'(bus.SC_STATEMACHINE_SELECT_OutBUS[3:2]), 3);
    press_start("t5_restart");
    chk("t5_idle", 32'(bus.SC_STATEMACHINE_STATE_OutBUS), 0);

    // T6: soft clear in crash, async reset in play
    press_start("t6_start");
    repeat (CD) cycle("t6_tick", 0, 1, 1, 0);
    cycle("t6_crash", 0, 1, 0, 1);
    cycle("t6_clear", 1, 1, 0, 0);
    chk("t6_clear_state", 32'(bus.SC_STATEMACHINE_STATE_OutBUS), 0);
    chk("t6_clear_lives", 32'(bus.SC_STATEMACHINE_LIVES_OutBUS), 3);
    chk("t6_clear_level", 32'(bus.SC_STATEMACHINE_LEVEL_OutBUS), 0);
    press_start("t6_start2");
    repeat (CD) cycle("t6_tick2", 0, 1, 1, 0);
    cycle("t6_crash2", 0, 1, 0, 1);
    repeat (CR) cycle("t6_tick3", 0, 1, 1, 0);
    chk("t6_in_play", 32'(bus.SC_STATEMACHINE_STATE_OutBUS), 2);
    @(negedge clk);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check_all("t6_async");
    chk("t6_async_state", 32'(bus.SC_STATEMACHINE_STATE_OutBUS), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized play against the model
    for (int i = 0; i < 3000; i++) begin
      cycle("rnd", ($urandom % 64) == 0, ($urandom % 5) != 0,
            ($urandom % 2) == 1, ($urandom % 8) == 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
